// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Ibex-to-Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // Wide enough for any sane DW; users slice off DW/8 bits.
    localparam int SEL_MAX_W = 64;
    localparam logic [SEL_MAX_W-1:0] SEL_FULL = '1;

endpackage

// File: rtl/wb_core_arbiter_if.sv
// Core-side request ports plus the Wishbone master port of the arbiter.
// master = arbiter view, slave = the core and Wishbone bus around it.
interface wb_core_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic          instr_req;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_rdata;
    logic          instr_err;

    logic          data_req;
    logic          data_gnt;
    logic          data_rvalid;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_rdata;
    logic          data_err;
    logic          data_we;
    logic [SW-1:0] data_be;
    logic [DW-1:0] data_wdata;

    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [SW-1:0] wb_sel;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack;
    logic          wb_err;
    logic          wb_stall;

    modport master (
        input  instr_req, instr_addr,
        input  data_req, data_addr, data_we, data_be, data_wdata,
        input  wb_dat_i, wb_ack, wb_err, wb_stall,
        output instr_gnt, instr_rvalid, instr_rdata, instr_err,
        output data_gnt, data_rvalid, data_rdata, data_err,
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o
    );

    modport slave (
        output instr_req, instr_addr,
        output data_req, data_addr, data_we, data_be, data_wdata,
        output wb_dat_i, wb_ack, wb_err, wb_stall,
        input  instr_gnt, instr_rvalid, instr_rdata, instr_err,
        input  data_gnt, data_rvalid, data_rdata, data_err,
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o
    );

endinterface

// File: rtl/wb_arb2.sv
// Two-input grant selection (bit 0 = instr, bit 1 = data).
// WB_ARB_RR_EN selects round-robin; otherwise data has fixed priority.
module wb_arb2
    import wb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    input  logic       en,
    output logic [1:0] grant
);

`ifdef WB_ARB_RR_EN
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (&req) begin
                grant = (last == OWN_INSTR) ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end
`else
    logic last_unused;
    assign last_unused = last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[1]) begin
                grant = 2'b10;
            end else if (req[0]) begin
                grant = 2'b01;
            end
        end
    end
`endif

endmodule

// File: rtl/wb_core_arbiter.sv
// Shares one Wishbone B4 pipelined master between Ibex fetch and LSU ports,
// one transaction outstanding at a time. Arbitration mode set by WB_ARB_RR_EN.
//
//   state | meaning
//   IDLE  | no transaction; grant a requester and latch its request
//   REQ   | cyc=1 stb=1, waiting for the slave to take the request (!stall)
//   WAIT  | cyc=1 stb=0, waiting for ack/err; response registered on arrival
module wb_core_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    wb_core_arbiter_if.master  bus
);
    localparam int SW = DW / 8;

    state_t     state;
    owner_t     owner;
    logic [1:0] req;
    logic [1:0] grant;
    logic       arb_en;

    assign req    = {bus.data_req, bus.instr_req};
    assign arb_en = (state == IDLE) && !rst;

    // owner doubles as the last-served pointer: it only changes on a grant.
    wb_arb2 u_arb (
        .req   (req),
        .last  (owner),
        .en    (arb_en),
        .grant (grant)
    );

    assign bus.instr_gnt = grant[0];
    assign bus.data_gnt  = grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            owner            <= OWN_INSTR;
            bus.instr_rvalid <= 1'b0;
            bus.instr_rdata  <= '0;
            bus.instr_err    <= 1'b0;
            bus.data_rvalid  <= 1'b0;
            bus.data_rdata   <= '0;
            bus.data_err     <= 1'b0;
            bus.wb_cyc       <= 1'b0;
            bus.wb_stb       <= 1'b0;
            bus.wb_we        <= 1'b0;
            bus.wb_adr       <= '0;
            bus.wb_sel       <= '0;
            bus.wb_dat_o     <= '0;
        end else begin
            bus.instr_rvalid <= 1'b0;
            bus.data_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant[1]) begin
                        owner        <= OWN_DATA;
                        bus.wb_adr   <= bus.data_addr;
                        bus.wb_we    <= bus.data_we;
                        bus.wb_sel   <= bus.data_be;
                        bus.wb_dat_o <= bus.data_wdata;
                        bus.wb_cyc   <= 1'b1;
                        bus.wb_stb   <= 1'b1;
                        state        <= REQ;
                    end else if (grant[0]) begin
                        owner        <= OWN_INSTR;
                        bus.wb_adr   <= bus.instr_addr;
                        bus.wb_we    <= 1'b0;
                        bus.wb_sel   <= SEL_FULL[SW-1:0];
                        bus.wb_dat_o <= '0;
                        bus.wb_cyc   <= 1'b1;
                        bus.wb_stb   <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (!bus.wb_stall) begin
                        bus.wb_stb <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.wb_ack || bus.wb_err) begin
                        bus.wb_cyc <= 1'b0;
                        if (owner == OWN_DATA) begin
                            bus.data_rdata  <= bus.wb_dat_i;
                            bus.data_err    <= bus.wb_err;
                            bus.data_rvalid <= 1'b1;
                        end else begin
                            bus.instr_rdata  <= bus.wb_dat_i;
                            bus.instr_err    <= bus.wb_err;
                            bus.instr_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
